// File: rtl/lab_hex_display_ctrl.sv
// lab_hex_display_ctrl
// ---------------------------------------------------------------------------
// Avalon-MM slave that drives NUM_DIGITS seven-segment displays. Software writes
// packed 4-bit hex values. The block decodes them in hardware and applies a
// global enable, per-digit blanking and optional per-digit blinking. It produces
// registered, active-low segment outputs.
//
// Optional feature macro: HEX_DISPLAY_BLINK_EN
//   defined   - blink counter, blink phase and BLINK mask are implemented.
//   undefined - no counter logic. BLINK mask bits and STATUS bit0 read 0, and
//               blinking never darkens a digit.
//
// Register map (word addresses):
//   0 DATA   RW  [4N-1:0]  nibble per digit, digit i at [4i+3:4i]
//   1 CTRL   RW  bit0 ENABLE, [8+N-1:8] BLANK mask, [16+N-1:16] BLINK mask
//   2 STATUS RO  bit0 blink phase, bit1 ENABLE echo
//   3..7         writes ignored, reads 0
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous, active-low reset
//   address    in   word address of register
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   write data
//   readdata   out  read data, combinational from address (no wait states)
//   out_port   out  segments, digit i at [7i+6:7i], order {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module lab_hex_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [2:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic [7*NUM_DIGITS-1:0]   out_port
);

  localparam int unsigned DataW = 4 * NUM_DIGITS;
  localparam int unsigned SegW  = 7 * NUM_DIGITS;

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrCtrl   = 3'd1;
  localparam logic [2:0] AddrStatus = 3'd2;

  // Elaboration-time parameter sanity checks.
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : gen_bad_num_digits
    $error("lab_hex_display_ctrl: NUM_DIGITS must be in 1..8");
  end
  if (BLINK_DIV < 1) begin : gen_bad_blink_div
    $error("lab_hex_display_ctrl: BLINK_DIV must be >= 1");
  end

  // -------------------------------------------------------------------------
  // Bus write decode
  // -------------------------------------------------------------------------
  logic w_wr;
  logic w_wr_data;
  logic w_wr_ctrl;
  logic w_unused_wdata;

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_data = w_wr & (address == AddrData);
  assign w_wr_ctrl = w_wr & (address == AddrCtrl);

  // Only some writedata bits are stored, depending on NUM_DIGITS and config.
  assign w_unused_wdata = ^writedata;

  // -------------------------------------------------------------------------
  // DATA and CTRL (ENABLE, BLANK) registers
  // -------------------------------------------------------------------------
  logic [DataW-1:0]      r_data;
  logic                  r_enable;
  logic [NUM_DIGITS-1:0] r_blank;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (w_wr_data) begin
      r_data <= writedata[DataW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable <= 1'b1;
      r_blank  <= '0;
    end else if (w_wr_ctrl) begin
      r_enable <= writedata[0];
      r_blank  <= writedata[8 +: NUM_DIGITS];
    end
  end

  // -------------------------------------------------------------------------
  // Blink mask, counter and phase
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] w_blink_mask;
  logic                  w_phase;

`ifdef HEX_DISPLAY_BLINK_EN
  localparam int unsigned   CntW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BLINK_DIV - 1);

  logic [NUM_DIGITS-1:0] r_blink;
  logic [CntW-1:0]       r_cnt;
  logic                  r_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink <= '0;
    end else if (w_wr_ctrl) begin
      r_blink <= writedata[16 +: NUM_DIGITS];
    end
  end

  // A CTRL write restarts the blink period so newly blinking digits begin lit.
  // It also wins over a wrap on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CntMax) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign w_blink_mask = r_blink;
  assign w_phase      = r_phase;
`else
  assign w_blink_mask = '0;
  assign w_phase      = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Hex to active-low segment decode, bit order {g,f,e,d,c,b,a}
  // -------------------------------------------------------------------------
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    unique case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // -------------------------------------------------------------------------
  // Segment output: combinational next value, then one output register so the
  // header pins never see decode glitches.
  // -------------------------------------------------------------------------
  logic [SegW-1:0] w_out;
  logic [SegW-1:0] r_out;

  always_comb begin
    w_out = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_enable && !r_blank[i] && !(w_blink_mask[i] && w_phase)) begin
        w_out[7*i +: 7] = hex_to_seg(r_data[4*i +: 4]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '1;
    end else begin
      r_out <= w_out;
    end
  end

  assign out_port = r_out;

  // -------------------------------------------------------------------------
  // Read mux (combinational, side-effect free)
  // -------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      AddrData: begin
        readdata[DataW-1:0] = r_data;
      end
      AddrCtrl: begin
        readdata[0]               = r_enable;
        readdata[8 +: NUM_DIGITS]  = r_blank;
        readdata[16 +: NUM_DIGITS] = w_blink_mask;
      end
      AddrStatus: begin
        readdata[0] = w_phase;
        readdata[1] = r_enable;
      end
      default: begin
        readdata = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_lab_hex_display_ctrl.sv
// Self-checking bench for lab_hex_display_ctrl (NUM_DIGITS=2, BLINK_DIV=4).
// The stimulus side keeps a behavioural model of the register file and the blink
// timing. Blink phase is derived from the elapsed cycles since the last restart.
// For every cycle it queues the expected out_port and readdata. A monitor
// pops the queue on each falling edge and compares.
module tb_lab_hex_display_ctrl;

  localparam int unsigned N   = 2;
  localparam int unsigned Div = 4;
  localparam int unsigned OW  = 7 * N;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [OW-1:0] out_port;

  always #5 clk = ~clk;

  lab_hex_display_ctrl #(
    .NUM_DIGITS (N),
    .BLINK_DIV  (Div)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic [3:0]    m_nib   [N];
  bit            m_enable;
  bit            m_blank [N];
  bit            m_blink [N];
  int            m_ticks;   // edges since reset release or last CTRL write
  logic [OW-1:0] m_shown;   // what out_port must show during the current cycle

  typedef struct packed {
    logic [OW-1:0] out;
    logic [31:0]   rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic bit model_phase();
`ifdef HEX_DISPLAY_BLINK_EN
    return ((m_ticks / Div) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [OW-1:0] o;
    o = '1;
    for (int i = 0; i < N; i++) begin
      if (m_enable && !m_blank[i] && !(m_blink[i] && model_phase()))
        o[7*i +: 7] = seg_tab[m_nib[i]];
    end
    return o;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 3'd0) begin
      for (int i = 0; i < N; i++) r[4*i +: 4] = m_nib[i];
    end else if (a == 3'd1) begin
      r[0] = m_enable;
      for (int i = 0; i < N; i++) begin
        r[8+i]  = m_blank[i];
        r[16+i] = m_blink[i];
      end
    end else if (a == 3'd2) begin
      r[0] = model_phase();
      r[1] = m_enable;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_nib[i]   = 4'h0;
      m_blank[i] = 1'b0;
      m_blink[i] = 1'b0;
    end
    m_enable = 1'b1;
    m_ticks  = 0;
  endtask

  // One bus cycle: drive inputs, queue expectations, advance the model by one edge.
  task automatic step(input bit rst, input bit cs, input bit wn,
                      input logic [2:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset_n    = !rst;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    if (rst) begin
      model_reset();
      m_shown = '1;
    end
    sb_q.push_back('{out: m_shown, rd: model_read(a)});
    if (!rst) begin
      m_shown = model_out();
      if (cs && !wn && a == 3'd0) begin
        for (int i = 0; i < N; i++) m_nib[i] = wd[4*i +: 4];
      end
      if (cs && !wn && a == 3'd1) begin
        m_enable = wd[0];
        for (int i = 0; i < N; i++) begin
          m_blank[i] = wd[8+i];
`ifdef HEX_DISPLAY_BLINK_EN
          m_blink[i] = wd[16+i];
`else
          m_blink[i] = 1'b0;
`endif
        end
        m_ticks = 0;
      end else begin
        m_ticks++;
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        n_tests++;
        if (out_port !== e.out) begin
          n_fail++;
          $display("FAIL out_port @%0t: got %b expected %b", $time, out_port, e.out);
        end
        n_tests++;
        if (readdata !== e.rd) begin
          n_fail++;
          $display("FAIL readdata addr=%0d @%0t: got %h expected %h",
                   address, $time, readdata, e.rd);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          rst, cs, wn;
    logic [2:0]  a;
    logic [31:0] wd;
    int          guard;

    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;
    model_reset();
    m_shown = '1;

    // Reset and release
    repeat (3) step(1'b1, 1'b0, 1'b1, 3'd1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 3'd1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 3'd2, 32'h0);

    // DATA writes, including stray upper bits
    step(1'b0, 1'b1, 1'b0, 3'd0, 32'h0000_003A);
    step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 32'hFFFF_FF3A);
    step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_0055);   // no chipselect: ignored

    // Blank digit0, then disable
    step(1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_0101);
    step(1'b0, 1'b0, 1'b1, 3'd1, 32'h0);
    step(1'b0, 1'b1, 1'b0, 3'd1, 32'h0000_0000);
    step(1'b0, 1'b0, 1'b1, 3'd2, 32'h0);
    step(1'b0, 1'b0, 1'b1, 3'd2, 32'h0);

    // Blink digit1, restart mid-dark
    step(1'b0, 1'b1, 1'b0, 3'd1, 32'h0002_0001);
    repeat (14) step(1'b0, 1'b0, 1'b1, 3'd2, 32'h0);
    step(1'b0, 1'b1, 1'b0, 3'd1, 32'h0002_0001);
    repeat (12) step(1'b0, 1'b0, 1'b1, 3'd2, 32'h0);

    // Unmapped address
    step(1'b0, 1'b1, 1'b0, 3'd5, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 1'b1, 3'd5, 32'h0);
    step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 3'd1, 32'h0);

    // Reset while blinking
    step(1'b0, 1'b1, 1'b0, 3'd1, 32'h0003_0001);
    repeat (6) step(1'b0, 1'b0, 1'b1, 3'd2, 32'h0);
    repeat (2) step(1'b1, 1'b0, 1'b1, 3'd1, 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);

    // Randomized traffic; CTRL writes kept rare so blink periods complete
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      cs  = ($urandom_range(0, 3) != 0);
      wn  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 0) a = 3'($urandom_range(0, 2));
      else                           a = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd1 && !wn) begin
        if ($urandom_range(0, 5) != 0) wn = 1'b1;
        wd[0] = ($urandom_range(0, 7) != 0);
      end
      step(rst, cs, wn, a, wd);
    end

    step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lab_hex_display_ctrl.md
# lab_hex_display_ctrl

Parametrised Avalon-MM slave that drives NUM_DIGITS seven-segment displays from packed 4-bit hex values, with hardware hex decode, per-digit blanking, per-digit blinking and a global enable. It sits on the lab system interconnect in place of raw-segment PIO ports: software writes hex values, and the block produces registered, active-low segment outputs for the board headers.

## Interface
- NUM_DIGITS, 2, number of digits driven (1..8)
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=1)

- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- address  in  3  word address of register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address
- out_port  out  7*NUM_DIGITS  segments, digit i at [7i+6:7i], bit order {g,f,e,d,c,b,a}, active-low

## Operation
- Register map; writes are qualified by chipselect && !write_n:
  - 0 DATA: RW; [4N-1:0] holds nibble per digit, digit i at [4i+3:4i].
  - 1 CTRL: RW; bit0 ENABLE, [8+N-1:8] BLANK mask, [16+N-1:16] BLINK mask.
  - 2 STATUS: RO; bit0 blink phase, bit1 ENABLE echo.
  - 3..7: writes ignored, reads 0. Unimplemented bits read 0.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Digit i is dark (1111111) when ENABLE=0, or BLANK[i]=1, or (BLINK[i]=1 and phase=1). Otherwise it shows decode(DATA nibble i).
- Blink counter runs 0..BLINK_DIV-1. At BLINK_DIV-1 it wraps to 0 and toggles phase.
- Any write to CTRL clears the counter and phase in the same edge, so newly blinking digits start visible.
- The counter runs regardless of ENABLE.

## Timing
- Reset values: DATA=0, CTRL=0x00000001, counter=0, phase=0, out_port=all ones.
- Write latency: register updates at write edge k; out_port reflects it at edge k+1. The one-cycle output register is glitch-free.
- Phase toggle at edge k is visible on out_port at edge k+1.
- Read: readdata is valid in the same cycle as address, with no wait states. Reads have no side effects.
- Reset assertion mid-operation immediately forces all registers to reset values and blanks out_port.
- A CTRL write on the same edge as a counter wrap takes precedence: counter=0, phase=0.

## Configuration
- HEX_DISPLAY_BLINK_EN defined: the blink counter, phase and BLINK mask are implemented as above.
- Not defined: no counter logic; BLINK mask bits are not stored and read 0; STATUS bit0 reads 0; blink never darkens a digit; BLINK_DIV is unused.

## Test plan
- Reset, NUM_DIGITS=2 -> out_port=14'h3FFF during reset; one cycle after release -> 14'b1000000_1000000, DATA=0, CTRL reads 0x1.
- Write DATA=0x3A -> readdata 0x3A at address 0; next cycle out_port={0110000,0001000}. Write DATA=0xFFFFFF3A -> readback 0x3A.
- Write CTRL=0x00000101 (BLANK digit0) -> digit0=1111111, digit1 decoded. Write CTRL=0 -> both digits 1111111, STATUS=0.
- With HEX_DISPLAY_BLINK_EN and BLINK_DIV=4, write CTRL=0x00020001 -> digit1 lit 4 cycles, dark 4 cycles, repeating; STATUS bit0 toggles every 4 cycles. A CTRL rewrite mid-dark restarts with digit1 lit.
- Without HEX_DISPLAY_BLINK_EN, the same CTRL write -> readback 0x1, digit1 always lit.
- Write to address 5 -> no register changes, reads 0. Assert reset_n while digits blink -> out_port all ones asynchronously.
